fc_accum_binarize: RTL and testbench

//  Consumer end of the binary-weight product stream. Accepts one signed 9-bit
//  (+/-1)*pixel product per handshake and accumulates IN_LEN of them plus a

---
 rtl/bnn_pkg.sv | 18 +
 rtl/bnn_sat_clip.sv | 24 ++
 rtl/fc_accum_binarize.sv | 113 +++++++++++
 tb/tb_fc_accum_binarize.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared definitions for the binary-weight FC/1x1 datapath blocks:
// default widths, accumulator sizing helper and the accumulate/hold state type.
package bnn_pkg;

  localparam int DATA_W_DEF = 9;
  localparam int IN_LEN_DEF = 64;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } fc_state_t;

  // Wide enough for IN_LEN full-scale products plus one bit of bias headroom.
  function automatic int acc_width(input int data_w, input int in_len);
    return data_w + $clog2(in_len) + 1;
  endfunction

endpackage

// File: rtl/bnn_sat_clip.sv
// Signed saturating narrowing: clips an IN_W two's complement value into the
// representable range of an OUT_W two's complement value.
module bnn_sat_clip #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 9
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  localparam logic signed [IN_W-1:0] HI = IN_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] LO = ~HI;

  // Pass through in range, otherwise pin to the nearest rail.
  always_comb begin
    dout = din[OUT_W-1:0];
    if (din > HI) begin
      dout = HI[OUT_W-1:0];
    end else if (din < LO) begin
      dout = LO[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/fc_accum_binarize.sv
// Consumer end of the binary-weight product stream. Accumulates IN_LEN signed
// (+/-1)*pixel products plus a bias and presents the full-precision sum, its
// BNN sign bit and a DATA_W-wide requantized activation.
// Build option: define FC_ACT_SAT_EN to saturate the activation instead of
// truncating it to its low DATA_W bits.
module fc_accum_binarize
  import bnn_pkg::*;
#(
  parameter int  DATA_W = DATA_W_DEF,
  parameter int  IN_LEN = IN_LEN_DEF,
  localparam int ACC_W  = acc_width(DATA_W, IN_LEN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [ACC_W-1:0]  bias,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_sum,
  output logic                     out_bit,
  output logic        [DATA_W-1:0] out_act
);

  localparam int              CNT_W = $clog2(IN_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(IN_LEN - 1);

  fc_state_t               state;
  fc_state_t               state_next;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] in_ext;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_next;
  logic [DATA_W-1:0]       act_next;
  logic                    beat;
  logic                    last_beat;

  assign beat      = in_valid & in_ready;
  assign last_beat = beat & (cnt == LAST);

  // State register: ACC while collecting products, HOLD while a result waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
    end else begin
      state <= state_next;
    end
  end

  // Next state: leave ACC on the final beat, leave HOLD once the result is taken.
  always_comb begin
    state_next = state;
    case (state)
      ACC:     if (last_beat) state_next = HOLD;
      HOLD:    if (out_ready) state_next = ACC;
      default: state_next = ACC;
    endcase
  end

  // Handshake outputs are a pure function of the state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACC:     in_ready  = 1'b1;
      HOLD:    out_valid = 1'b1;
      default: in_ready  = 1'b1;
    endcase
  end

  // The first beat of a vector seeds from the bias rather than the stale sum.
  always_comb begin
    in_ext   = {{(ACC_W - DATA_W){in_data[DATA_W-1]}}, in_data};
    acc_base = (cnt == '0) ? bias : acc;
    acc_next = acc_base + in_ext;
  end

`ifdef FC_ACT_SAT_EN
  bnn_sat_clip #(
    .IN_W  (ACC_W),
    .OUT_W (DATA_W)
  ) u_sat_clip (
    .din  (acc_next),
    .dout (act_next)
  );
`else
  assign act_next = acc_next[DATA_W-1:0];
`endif

  // Accumulate accepted beats; capture the result registers on the final beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc     <= '0;
      out_sum <= '0;
      out_bit <= 1'b0;
      out_act <= '0;
    end else if (beat) begin
      acc <= acc_next;
      if (cnt == LAST) begin
        cnt     <= '0;
        out_sum <= acc_next;
        out_bit <= ~acc_next[ACC_W-1];
        out_act <= act_next;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fc_accum_binarize.sv
// Self-checking bench for fc_accum_binarize at IN_LEN=4. Expected values come
// from directed tables and an integer reference model of bias + sum(products).
// Build with or without FC_ACT_SAT_EN; the activation model follows the macro.
module tb_fc_accum_binarize;

  localparam int DATA_W = 9;
  localparam int IN_LEN = 4;
  localparam int ACC_W  = DATA_W + $clog2(IN_LEN) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [ACC_W-1:0]  bias;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_bit;
  logic [DATA_W-1:0] out_act;

  int errors = 0;
  int checks = 0;
  int vec[IN_LEN];

  fc_accum_binarize #(
    .DATA_W (DATA_W),
    .IN_LEN (IN_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_bit   (out_bit),
    .out_act   (out_act)
  );

  always #5 clk = ~clk;

  // Reference: integer bias plus products, wrapped to the accumulator width.
  function automatic int model_sum(input int b);
    int s;
    logic signed [ACC_W-1:0] w;
    s = b;
    for (int i = 0; i < IN_LEN; i++) s += vec[i];
    w = ACC_W'(s);
    return int'(w);
  endfunction

  function automatic int model_act(input int s);
    logic signed [DATA_W-1:0] t;
`ifdef FC_ACT_SAT_EN
    if (s > 255) return 255;
    if (s < -256) return -256;
    return s;
`else
    t = DATA_W'(s);
    return int'(t);
`endif
  endfunction

  // Drive one vector from vec[], optionally with random idle gaps between beats.
  // The bias port is scrambled after the first beat since only that beat samples it.
  task automatic drive_vector(input int bias_v, input int max_gap, output bit ok);
    int waited;
    ok = 1'b1;
    for (int i = 0; i < IN_LEN; i++) begin
      waited = 0;
      while (in_ready !== 1'b1 && waited < 20) begin
        @(posedge clk); #1;
        waited++;
      end
      if (waited >= 20) ok = 1'b0;
      bias     = (i == 0) ? ACC_W'(bias_v) : ACC_W'($urandom);
      in_data  = DATA_W'(vec[i]);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (max_gap > 0 && i < IN_LEN - 1) begin
        repeat ($urandom_range(max_gap, 0)) begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; bias = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_sum !== '0) begin errors++; $display("[TB] FAIL reset_out_sum: got %0d expected 0", out_sum); end
    checks++; if (out_bit !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_bit: got %b expected 0", out_bit); end
    checks++; if (out_act !== '0) begin errors++; $display("[TB] FAIL reset_out_act: got %0d expected 0", out_act); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_handshake: got ready=%b valid=%b expected 1/0", in_ready, out_valid); end
  endtask

  task automatic test_directed();
    int d_bias[5]     = '{0, -20, 0, 0, -3};
    int d_beats[5][4] = '{'{5, -3, 7, -1}, '{5, -3, 7, -1}, '{255, 255, 255, 255},
                          '{-256, -256, -256, -256}, '{1, 1, 1, 0}};
    int d_sum[5]      = '{8, -12, 1020, -1024, 0};
    int d_bit[5]      = '{1, 0, 1, 0, 1};
`ifdef FC_ACT_SAT_EN
    int d_act[5]      = '{8, -12, 255, -256, 0};
`else
    int d_act[5]      = '{8, -12, -4, 0, 0};
`endif
    bit ok;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < IN_LEN; i++) vec[i] = d_beats[c][i];
      drive_vector(d_bias[c], 0, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL dir%0d_ready_timeout: got timeout expected ready", c); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL dir%0d_valid_latency: got %b expected 1", c, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL dir%0d_in_ready: got %b expected 0", c, in_ready); end
      checks++; if (out_sum !== ACC_W'(d_sum[c])) begin errors++; $display("[TB] FAIL dir%0d_sum: got %0d expected %0d", c, $signed(out_sum), d_sum[c]); end
      checks++; if (out_bit !== 1'(d_bit[c])) begin errors++; $display("[TB] FAIL dir%0d_bit: got %b expected %0d", c, out_bit, d_bit[c]); end
      checks++; if (out_act !== DATA_W'(d_act[c])) begin errors++; $display("[TB] FAIL dir%0d_act: got %0d expected %0d", c, $signed(out_act), d_act[c]); end
      release_result();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL dir%0d_release: got ready=%b valid=%b expected 1/0", c, in_ready, out_valid); end
    end
  endtask

  task automatic test_hold();
    logic [ACC_W-1:0] held;
    int exp;
    bit ok;
    vec = '{100, -50, 25, 3};
    drive_vector(-7, 0, ok);
    held = out_sum;
    checks++; if (out_sum !== ACC_W'(model_sum(-7))) begin errors++; $display("[TB] FAIL hold_sum: got %0d expected %0d", $signed(out_sum), model_sum(-7)); end
    in_valid = 1'b1;
    in_data  = DATA_W'(77);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_handshake%0d: got valid=%b ready=%b expected 1/0", k, out_valid, in_ready); end
      checks++; if (out_sum !== held) begin errors++; $display("[TB] FAIL hold_stable%0d: got %0d expected %0d", k, $signed(out_sum), $signed(held)); end
    end
    in_valid = 1'b0;
    release_result();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL hold_release_ready: got %b expected 1", in_ready); end
    vec = '{1, 2, 3, 4};
    drive_vector(5, 0, ok);
    exp = model_sum(5);
    checks++; if (out_valid !== 1'b1 || out_sum !== ACC_W'(exp)) begin errors++; $display("[TB] FAIL hold_next_vector: got valid=%b sum=%0d expected 1/%0d", out_valid, $signed(out_sum), exp); end
    release_result();
  endtask

  task automatic test_reset_mid();
    bit ok;
    for (int g = 0; g < 2; g++) begin
      in_valid = 1'b1; bias = '0;
      in_data = DATA_W'(50);
      @(posedge clk); #1;
      in_data = DATA_W'(60);
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n = 1'b0;
      #2;
      checks++; if (out_valid !== 1'b0 || out_sum !== '0) begin errors++; $display("[TB] FAIL midrst%0d_clear: got valid=%b sum=%0d expected 0/0", g, out_valid, $signed(out_sum)); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      vec = '{1, 2, 3, 4};
      drive_vector(0, g * 3, ok);
      checks++; if (!ok || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL midrst%0d_valid: got valid=%b expected 1", g, out_valid); end
      checks++; if (out_sum !== ACC_W'(10)) begin errors++; $display("[TB] FAIL midrst%0d_sum: got %0d expected 10", g, $signed(out_sum)); end
      release_result();
    end
  endtask

  task automatic test_random();
    int b;
    int exp;
    bit ok;
    for (int n = 0; n < 24; n++) begin
      b = int'($urandom_range(2048, 0)) - 1024;
      for (int i = 0; i < IN_LEN; i++) vec[i] = int'($urandom_range(511, 0)) - 256;
      exp = model_sum(b);
      drive_vector(b, 2, ok);
      repeat ($urandom_range(3, 0)) begin
        @(posedge clk); #1;
      end
      checks++; if (!ok || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rnd%0d_valid: got valid=%b expected 1", n, out_valid); end
      checks++; if (out_sum !== ACC_W'(exp)) begin errors++; $display("[TB] FAIL rnd%0d_sum: got %0d expected %0d", n, $signed(out_sum), exp); end
      checks++; if (out_bit !== (exp >= 0)) begin errors++; $display("[TB] FAIL rnd%0d_bit: got %b expected %0d", n, out_bit, exp >= 0); end
      checks++; if (out_act !== DATA_W'(model_act(exp))) begin errors++; $display("[TB] FAIL rnd%0d_act: got %0d expected %0d", n, $signed(out_act), model_act(exp)); end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
